// File: rtl/div_share_pkg.sv
// rtl/div_share_pkg.sv - shared types and helpers for the divider-sharing arbiter
// Contents:
//   DATA_W_DEF : default operand width (matches the 16-bit restoring divider)
//   state_t    : arbiter FSM states (IDLE, ISSUE, WAIT, RESP)
//   id_width() : width of a requester index for a given requester count
package div_share_pkg;

    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Never returns less than one bit, so an index port always exists.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/div_share_arbiter_rr_grant.sv
// rtl/div_share_arbiter_rr_grant.sv - combinational round-robin picker
// Ports:
//   req        in  NUM_REQ  request vector
//   last_grant in  ID_W     index served most recently
//   grant_any  out 1        at least one request present
//   grant_idx  out ID_W     first set request searching upward from last_grant+1, wrapping
module rr_grant
    import div_share_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_grant,
    output logic               grant_any,
    output logic [ID_W-1:0]    grant_idx
);

    logic [ID_W-1:0] cand;

    // Walk every position once, starting just after last_grant; the first
    // hit is latched so later candidates cannot override it.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = last_grant;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = (cand >= ID_W'(NUM_REQ - 1)) ? '0 : cand + ID_W'(1);
            if (!grant_any && req[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

endmodule

// File: rtl/div_share_arbiter.sv
// rtl/div_share_arbiter.sv - shares one external divider between NUM_REQ requesters
// Optional build macro: DIV_ZERO_BYPASS_EN (answer divide-by-zero locally, no divider call)
// Ports:
//   clk, rst (async, active low)
//   req_valid/req_ready, req_dividend/req_divisor : packed per-requester request channel
//   resp_valid/resp_ready, resp_id, resp_quotient, resp_reminder, resp_err : tagged response
//   div_valid_src, div_dividend, div_divisor : start and operands to the divider
//   div_valid_des, div_quotient, div_reminder : divider completion and results
module div_share_arbiter
    import div_share_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 40
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*DATA_W-1:0]   req_dividend,
    input  logic [NUM_REQ*DATA_W-1:0]   req_divisor,
    output logic                        resp_valid,
    input  logic                        resp_ready,
    output logic [id_width(NUM_REQ)-1:0] resp_id,
    output logic [DATA_W-1:0]           resp_quotient,
    output logic [DATA_W-1:0]           resp_reminder,
    output logic                        resp_err,
    output logic                        div_valid_src,
    output logic [DATA_W-1:0]           div_dividend,
    output logic [DATA_W-1:0]           div_divisor,
    input  logic                        div_valid_des,
    input  logic [DATA_W-1:0]           div_quotient,
    input  logic [DATA_W-1:0]           div_reminder
);

    localparam int ID_W  = id_width(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t            state, state_nxt;
    logic              grant_any;
    logic [ID_W-1:0]   grant_idx;
    logic [ID_W-1:0]   last_grant;
    logic [ID_W-1:0]   id_q;
    logic [DATA_W-1:0] sel_dividend, sel_divisor;
    logic [DATA_W-1:0] op_dividend, op_divisor;
    logic [DATA_W-1:0] res_q, res_r;
    logic              err_q;
    logic [CNT_W-1:0]  wait_cnt;
    logic              timeout_hit;
    logic              zero_byp;

    rr_grant #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_grant (
        .req        (req_valid),
        .last_grant (last_grant),
        .grant_any  (grant_any),
        .grant_idx  (grant_idx)
    );

    assign sel_dividend = req_dividend[int'(grant_idx) * DATA_W +: DATA_W];
    assign sel_divisor  = req_divisor[int'(grant_idx) * DATA_W +: DATA_W];

`ifdef DIV_ZERO_BYPASS_EN
    assign zero_byp = (sel_divisor == '0);
`else
    assign zero_byp = 1'b0;
`endif

    assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        req_ready     = '0;
        div_valid_src = 1'b0;
        resp_valid    = 1'b0;
        case (state)
            IDLE: begin
                if (grant_any) begin
                    // Gated by rst so the accept stays low while reset is held.
                    req_ready[grant_idx] = rst;
                    state_nxt            = zero_byp ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                div_valid_src = 1'b1;
                state_nxt     = WAIT;
            end
            WAIT: begin
                if (div_valid_des || timeout_hit) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant  <= ID_W'(NUM_REQ - 1);
            id_q        <= '0;
            op_dividend <= '0;
            op_divisor  <= '0;
            res_q       <= '0;
            res_r       <= '0;
            err_q       <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        op_dividend <= sel_dividend;
                        op_divisor  <= sel_divisor;
                        id_q        <= grant_idx;
                        if (zero_byp) begin
                            res_q <= '1;
                            res_r <= sel_dividend;
                            err_q <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    wait_cnt <= '0;
                end
                WAIT: begin
                    wait_cnt <= wait_cnt + CNT_W'(1);
                    // A completion landing on the timeout cycle still counts as success.
                    if (div_valid_des) begin
                        res_q <= div_quotient;
                        res_r <= div_reminder;
                        err_q <= 1'b0;
                    end else if (timeout_hit) begin
                        res_q <= '0;
                        res_r <= '0;
                        err_q <= 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        last_grant <= id_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign div_dividend  = op_dividend;
    assign div_divisor   = op_divisor;
    assign resp_id       = id_q;
    assign resp_quotient = res_q;
    assign resp_reminder = res_r;
    assign resp_err      = err_q;

endmodule

// File: doc/div_share_arbiter.md
Name: div_share_arbiter

Overview:
- Shares one 16-bit restoring divider between NUM_REQ requesters.
- Round-robin grant; accepts one request at a time and sequences the divider's valid_src/valid_des protocol.
- Returns quotient/remainder on a single tagged response channel with valid/ready.
- Sits between client blocks and the divider instance; the divider is instantiated outside this block.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 16, operand width; must equal the divider width.
- TIMEOUT, 40, maximum cycles in WAIT before aborting with an error.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero.
- req_dividend  in  NUM_REQ*DATA_W  packed dividends; requester i uses bits [i*DATA_W +: DATA_W].
- req_divisor  in  NUM_REQ*DATA_W  packed divisors, same packing.
- resp_valid  out  1  response valid.
- resp_ready  in  1  response accept.
- resp_id  out  $clog2(NUM_REQ)  index of the served requester.
- resp_quotient  out  DATA_W  quotient.
- resp_reminder  out  DATA_W  remainder.
- resp_err  out  1  timeout abort, or divide-by-zero when the optional feature is enabled.
- div_valid_src  out  1  start pulse to the divider.
- div_dividend  out  DATA_W  dividend to the divider.
- div_divisor  out  DATA_W  divisor to the divider.
- div_valid_des  in  1  divider done.
- div_quotient  in  DATA_W  divider quotient.
- div_reminder  in  DATA_W  divider remainder.

Behaviour:
- Reset (async, rst=0):
  - state=IDLE; all outputs 0; operand, result and id registers 0; wait counter 0.
  - last_grant=NUM_REQ-1, so requester 0 has first priority.
- Reset mid-operation abandons the transaction with no response. The external divider shares rst.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid is high, the grant g is the first set bit searching upward from last_grant+1, with wrap-around.
  - req_ready[g]=1 combinationally in that cycle.
  - Operands and id are latched at the clock edge; next state is ISSUE.
  - With no req_valid high, stay in IDLE.
- req_ready is 0 in every state except IDLE.
- ISSUE:
  - div_valid_src=1 for exactly one cycle.
  - Next state is WAIT; the wait counter is cleared.
- div_dividend and div_divisor are driven from the latched registers in ISSUE, WAIT and RESP, and are stable the whole time.
- WAIT:
  - The counter increments every cycle.
  - If div_valid_des=1: capture div_quotient/div_reminder, resp_err=0, go to RESP.
  - Else if counter==TIMEOUT-1: results=0, resp_err=1, go to RESP.
  - If div_valid_des arrives in the same cycle as the timeout, div_valid_des wins.
- RESP:
  - resp_valid=1; resp_id, resp_quotient, resp_reminder and resp_err are held stable until resp_ready=1.
  - On handshake: last_grant=resp_id, next state IDLE, resp_valid=0 the next cycle.
- No new grant is issued during RESP, so there is one transaction in flight at a time.
- Minimum turnaround: 1 (IDLE) + 1 (ISSUE) + divider latency + 1 (RESP with resp_ready high).
- A requester that holds req_valid receives service within NUM_REQ transactions (round-robin fairness).
- A requester drops req_valid only after its req_ready handshake.

Optional Feature:
- Macro: DIV_ZERO_BYPASS_EN.
- Defined:
  - In IDLE, a granted request with divisor==0 skips ISSUE/WAIT and goes directly to RESP.
  - Response is resp_quotient='1 (all ones), resp_reminder=dividend, resp_err=1.
  - div_valid_src is never pulsed for that request.
- Not defined: zero divisors are sent to the divider like any other request; the result is whatever the divider produces, with resp_err=0 unless a timeout occurs.

Decomposition:
- Package div_share_pkg holds:
  - DATA_W default;
  - the state enum typedef (IDLE, ISSUE, WAIT, RESP);
  - a function returning the width of resp_id.
- Sub-module rr_grant: combinational round-robin picker.
  - Inputs: req vector, last_grant.
  - Outputs: grant_any, grant_idx.
- The FSM, counter and registers stay in the top module.

Test Plan:
- Single request: requester 2 sends 100/7 with resp_ready=1 → one div_valid_src pulse; resp_id=2, quotient=14, remainder=2, resp_err=0.
- All four requesters hold valid with distinct operands (e.g. 50/3, 60/7, 9/9, 1/2) → service order 0,1,2,3, then 0 again; results correct per id.
- Response backpressure: resp_ready=0 for 10 cycles → resp_valid and data stable, no req_ready asserted, no div_valid_src pulse until the handshake.
- Divider stub never asserts div_valid_des → resp_err=1 and results 0 exactly TIMEOUT cycles after entering WAIT; the next request proceeds normally.
- rst asserted during WAIT → all outputs 0 immediately; after release, requester 0 is served first.
- DIV_ZERO_BYPASS_EN defined, request 1234/0 → no div_valid_src pulse; quotient=16'hFFFF, remainder=1234, resp_err=1. With the macro undefined, the request reaches the divider.
